load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage load/store unit sitting directly upstream of the word-addressed data memory (dataMem). It accepts one load/store request at a time from the pipeline. It converts byte addresses to word indices, performs read-modify-write for byte/halfword stores, and extracts and sign/zero-extends sub-word loads. Misaligned, reserved-size and out-of-range accesses are reported as faults and never touch memory.

Parameters:
DMEM_BITS, 10, log2 of data memory depth in 32-bit words; valid word indices are 0 .. 2**DMEM_BITS-1

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data; byte/half taken from LSBs
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and faults
resp_fault  output  1  valid with resp_valid; 1 = request rejected
mem_addr  output  32  word index to dataMem (= latched req_addr >> 2)
mem_write_en  output  1  dataMem write enable
mem_wdata  output  32  dataMem write data
mem_rdata  input  32  dataMem combinational read data for mem_addr

Behaviour:
- Reset: state IDLE; resp_valid 0, resp_rdata 0, resp_fault 0; mem_addr 0, mem_wdata 0, mem_write_en 0; req_ready 0 while reset is high.
- Handshake: req_ready = 1 only in IDLE with reset low. Accept on a rising edge where req_valid && req_ready. All req_* fields are latched at accept; later changes are ignored.
- Fault check at accept. Fault if any of:
  - req_size == 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:DMEM_BITS+2] != 0
- Fault path: go to RESP, then resp_valid = 1, resp_fault = 1, resp_rdata = 0. mem_write_en is never asserted.
- States and transitions:
  - IDLE -> ACCESS (legal accept) or RESP (fault).
  - ACCESS: mem_addr = latched word index.
    - Load: mem_rdata lane selected and extended into resp_rdata -> RESP.
    - Word store: mem_write_en = 1, mem_wdata = req_wdata -> RESP.
    - Byte/half store: mem_rdata merged with new lane into merge register -> WRITE.
  - WRITE: mem_write_en = 1, mem_wdata = merge register -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE.
- Latency from the accepting edge to resp_valid high:
  - 2 cycles for loads and word stores
  - 3 cycles for byte/half stores
  - 1 cycle for faults
- Next accept is possible the cycle after RESP (throughput of one request per 3 or 4 cycles).
- Lanes (little-endian):
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane]
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]]
  - Merge replaces only the addressed lane; other bytes are preserved from mem_rdata.
- Extension: signed replicates the lane MSB to bit 31. req_unsigned is ignored for words and stores.
- mem_write_en is decoded from the state register only (no input paths) and is high for exactly one cycle per store.
- mem_addr and mem_wdata hold their last value outside ACCESS/WRITE.
- Reset mid-operation: the next edge forces IDLE and drops any pending response. A WRITE not yet entered is never performed. Reset does not suppress mem_write_en in a cycle that is already ACCESS/WRITE.
- req_valid held high continuously: requests are accepted one at a time; none are lost or duplicated.

Test Plan:
1. Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_addr = 4, one mem_write_en pulse; load resp_rdata = 0xDEADBEEF, resp_fault = 0, resp_valid 2 cycles after accept.
2. Memory word 1 = 0x11223344; byte store 0xAA @0x05 -> 3-cycle latency, word becomes 0x1122AA44. Signed byte load @0x05 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
3. Word 2 = 0x80011234; signed half load @0x0A -> 0xFFFF8001; unsigned half load @0x08 -> 0x00001234.
4. Word store @0x13, half load @0x01, and size = 3 @0x00 -> each gives resp_fault = 1 one cycle after accept, no mem_write_en, memory unchanged.
5. DMEM_BITS = 10, word load @0x1000 -> fault; @0x0FFC -> normal access, mem_addr = 0x3FF.
6. Byte store accepted, reset asserted during the ACCESS cycle -> WRITE never entered, no mem_write_en that edge onward, resp_valid stays 0, req_ready = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store unit in front of a word-addressed data memory.
// Accepts one request at a time, converts the byte address to a word index,
// does read-modify-write for byte/halfword stores and extracts plus
// sign/zero-extends sub-word loads. Misaligned, reserved-size and
// out-of-range requests fault without touching memory.
//
// Latency from the accepting edge to resp_valid_o:
//   faults 1 cycle, loads and word stores 2 cycles, byte/half stores 3 cycles.
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   req_valid_i      request present
//   req_ready_o      request can be accepted this cycle (idle, not in reset)
//   req_we_i         1 = store, 0 = load
//   req_size_i       0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned_i   loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr_i       byte address
//   req_wdata_i      store data, sub-word data taken from the LSBs
//   resp_valid_o     one-cycle completion pulse
//   resp_rdata_o     load result (0 for stores and faults)
//   resp_fault_o     request rejected
//   mem_addr_o       word index into data memory
//   mem_write_en_o   data memory write enable
//   mem_wdata_o      data memory write data
//   mem_rdata_i      combinational read data for mem_addr_o
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned DMEM_BITS = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_write_en_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;
  localparam logic [1:0] SizeRsvd = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  // Doubles as the merge register for sub-word stores.
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        req_fault;
  logic        req_oor;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign req_ready_o = (state_q == StIdle) && !reset_i;
  assign accept      = req_valid_i && req_ready_o;

  // Any address bit above the top word index makes the access out of range.
  assign req_oor = (req_addr_i >> (DMEM_BITS + 2)) != 32'd0;

  always_comb begin
    req_fault = 1'b0;
    unique case (req_size_i)
      SizeByte: req_fault = 1'b0;
      SizeHalf: req_fault = req_addr_i[0];
      SizeWord: req_fault = (req_addr_i[1:0] != 2'b00);
      SizeRsvd: req_fault = 1'b1;
      default:  req_fault = 1'b1;
    endcase
    req_fault = req_fault || req_oor;
  end

  // --------------------------------------------------------------------------
  // Lane extraction / merge, little-endian
  // --------------------------------------------------------------------------
  assign byte_sel = 8'(mem_rdata_i >> {lane_q, 3'b000});
  assign half_sel = 16'(mem_rdata_i >> {lane_q[1], 4'b0000});

  always_comb begin
    load_data = mem_rdata_i;
    unique case (size_q)
      SizeByte: load_data = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SizeHalf: load_data = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  load_data = mem_rdata_i;
    endcase
  end

  // Only the addressed lane is replaced; the other bytes come from memory.
  always_comb begin
    merge_data = mem_rdata_i;
    if (size_q == SizeByte) begin
      merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          lane_d  = req_addr_i[1:0];
          wdata_d = req_wdata_i;
          rdata_d = 32'd0;
          fault_d = req_fault;
          if (req_fault) begin
            state_d = StResp;
          end else begin
            state_d    = StAccess;
            mem_addr_d = {2'b00, req_addr_i[31:2]};
            // Word stores write in the access cycle, so the data must be ready.
            if (req_we_i && (req_size_i == SizeWord)) begin
              mem_wdata_d = req_wdata_i;
            end
          end
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = load_data;
          state_d = StResp;
        end else if (size_q == SizeWord) begin
          state_d = StResp;
        end else begin
          mem_wdata_d = merge_data;
          state_d     = StWrite;
        end
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      lane_q      <= 2'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      fault_q     <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all decoded from registers
  // --------------------------------------------------------------------------
  assign resp_valid_o   = (state_q == StResp);
  assign resp_rdata_o   = rdata_q;
  assign resp_fault_o   = fault_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_write_en_o = (state_q == StWrite) ||
                          ((state_q == StAccess) && we_q && (size_q == SizeWord));

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned DmemBits = 10;
  localparam int unsigned Depth    = 1 << DmemBits;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Backdoor port used only to preload the memory while the DUT is idle.
  logic                bd_we;
  logic [DmemBits-1:0] bd_idx;
  logic [31:0]         bd_data;

  logic [31:0] dmem    [Depth];
  logic [31:0] ref_mem [Depth];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .DMEM_BITS(DmemBits)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_unsigned_i(req_unsigned),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .resp_fault_o  (resp_fault),
    .mem_addr_o    (mem_addr),
    .mem_write_en_o(mem_write_en),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[DmemBits-1:0]];

  always @(posedge clk) begin
    if (bd_we) dmem[bd_idx] <= bd_data;
    else if (mem_write_en) dmem[mem_addr[DmemBits-1:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int unsigned idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx[DmemBits-1:0];
    bd_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One complete transaction, checked against a model of the request rules.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic              exp_fault;
    int unsigned       exp_lat;
    int unsigned       exp_writes;
    logic [31:0]       exp_rdata;
    logic [31:0]       new_word;
    logic [31:0]       w;
    logic [31:0]       v;
    int unsigned       lane;
    int unsigned       idx;
    int unsigned       lat;
    int unsigned       writes;

    lane = int'(addr[1:0]);
    idx  = int'(addr[DmemBits+1:2]);
    exp_fault = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= Depth * 4);
    w = ref_mem[idx];
    exp_rdata = 32'd0;
    new_word  = w;
    if (!exp_fault && !we) begin
      if (size == 2'd0) begin
        v = (w >> (8 * lane)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2'd1) begin
        v = (w >> (8 * lane)) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = w;
      end
      exp_rdata = v;
    end
    if (!exp_fault && we) begin
      if (size == 2'd0)
        new_word = (w & ~(32'hFF << (8 * lane))) | ((wdata & 32'hFF) << (8 * lane));
      else if (size == 2'd1)
        new_word = (w & ~(32'hFFFF << (8 * lane))) | ((wdata & 32'hFFFF) << (8 * lane));
      else
        new_word = wdata;
    end
    exp_lat    = exp_fault ? 1 : ((we && size != 2'd2) ? 3 : 2);
    exp_writes = (!exp_fault && we) ? 1 : 0;

    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    check_eq("ready_before", 32'(req_ready), 32'd1);

    lat    = 0;
    writes = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Scramble the request; the DUT must use its latched copy.
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (!exp_fault) check_eq("acc_addr", mem_addr, addr >> 2);
      end
      if (mem_write_en) begin
        writes++;
        check_eq("wr_addr", mem_addr, addr >> 2);
        check_eq("wr_data", mem_wdata, new_word);
      end
      if (resp_valid) begin
        lat = n;
        check_eq("rdata", resp_rdata, exp_rdata);
        check_eq("fault", 32'(resp_fault), 32'(exp_fault));
      end
    end
    check_eq("latency", lat, exp_lat);
    check_eq("writes", writes, exp_writes);

    @(negedge clk);
    check_eq("resp_pulse", 32'(resp_valid), 32'd0);
    check_eq("wen_after", 32'(mem_write_en), 32'd0);
    check_eq("ready_after", 32'(req_ready), 32'd1);
    ref_mem[idx] = new_word;
    check_eq("mem_word", dmem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    bd_we = 1'b0; bd_idx = '0; bd_data = 32'd0;

    repeat (2) @(negedge clk);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_resp_fault", 32'(resp_fault), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_we", 32'(mem_write_en), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);

    // Fill memory with random contents while held in reset.
    for (int i = 0; i < int'(Depth); i++) begin
      bd_we   = 1'b1;
      bd_idx  = i[DmemBits-1:0];
      bd_data = $urandom;
      ref_mem[i] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Word store / load round trip.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    // Byte store merge and extension.
    poke(1, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'h05, 32'h000000AA);
    check_eq("merged_word", dmem[1], 32'h1122AA44);
    do_req(1'b0, 2'd0, 1'b0, 32'h05, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h05, 32'h0);
    // Half loads.
    poke(2, 32'h80011234);
    do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h08, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h5678ABCD);
    // Faults.
    do_req(1'b1, 2'd2, 1'b0, 32'h13, 32'hCAFEF00D);
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h00, 32'h12345678);
    // Range boundary.
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h1000, 32'h77);
    do_req(1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0FFF, 32'h000000C3);
    do_req(1'b0, 2'd0, 1'b0, 32'h0FFF, 32'h0);

    // Reset during the access cycle of a byte store: no write, no response.
    poke(7, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h1D; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    check_eq("rst_mid_wen_access", 32'(mem_write_en), 32'd0);
    check_eq("rst_mid_resp_access", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_wen", 32'(mem_write_en), 32'd0);
    check_eq("rst_mid_resp", 32'(resp_valid), 32'd0);
    check_eq("rst_mid_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_ready", 32'(req_ready), 32'd1);
      check_eq("post_rst_resp", 32'(resp_valid), 32'd0);
      check_eq("post_rst_wen", 32'(mem_write_en), 32'd0);
    end
    check_eq("post_rst_mem", dmem[7], ref_mem[7]);

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      r_we   = 1'($urandom);
      r_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) != 0) begin
        if (r_size == 2'd1) r_addr[0] = 1'b0;
        if (r_size == 2'd2) r_addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) r_addr = $urandom | 32'h0010_0000;
      do_req(r_we, r_size, 1'($urandom), r_addr, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
